johnson_decoder: RTL

- Receiving end of the Johnson-counter interface: samples an N-stage Johnson-coded bus, checks every code is one of the 2N legal patterns, and decodes it to a binary phase index.
- Tracks step-by-step progression, acquires lock after consecutive good steps, and counts completed revolutions.
- Used wherever a Johnson-counter state bus is read as a position or phase by downstream logic, or must be monitored for corruption.

---
 rtl/johnson_pkg.sv | 29 ++
 rtl/johnson_code_check.sv | 27 ++
 rtl/johnson_decoder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Shared types for the Johnson-code receiver: FSM states, step classes,
// and the phase-width helper used to size decoded phase buses.
package johnson_pkg;

  // Tracking state of the receiver
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCK   = 2'd2
  } state_t;

  // How a new legal phase relates to the previous one
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_BWD  = 2'd2,
    STEP_BAD  = 2'd3
  } step_t;

  // Bits needed to hold a phase index 0..2N-1
  function automatic int phase_w(input int n);
    return (n < 1) ? 1 : $clog2(2 * n);
  endfunction

  localparam int DEF_N = 4;

  typedef logic [phase_w(DEF_N)-1:0] phase_t;

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and binary decode of an N-stage Johnson code.
// A legal code has at most one transition between neighbouring stages.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = phase_w(N)
) (
  input  logic [0:N-1]  code_in,
  output logic          legal,
  output logic [PW-1:0] phase
);

  // Count stage-to-stage transitions for legality; popcount gives the phase
  always_comb begin
    int ones;
    int edges;
    ones  = $countones(code_in);
    edges = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (code_in[i] != code_in[i+1]) edges = edges + 1;
    end
    legal = (edges <= 1);
    phase = code_in[N-1] ? PW'(2 * N - ones) : PW'(ones);
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes the sampled bus to a phase index, tracks
// step progression, locks after LOCK_CNT good steps and counts revolutions.
// Define JOHN_DEC_BIDIR_EN to accept backward steps and count down revolutions.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int RW       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:N-1]           code_in,
  input  logic                   code_vld,
  output logic [phase_w(N)-1:0]  phase_out,
  output logic                   phase_vld,
  output logic                   illegal,
  output logic                   step_err,
  output logic                   locked,
  output logic [RW-1:0]          rev_cnt
);

  localparam int PW = phase_w(N);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [PW-1:0] LAST = PW'(2 * N - 1);
  localparam logic [GW-1:0] GOAL = GW'(LOCK_CNT);

  logic          legal;
  logic [PW-1:0] dec;
  logic [PW-1:0] nxt;
  logic [GW-1:0] good_cnt;
  logic [GW-1:0] gc_inc;
  state_t        state;
  step_t         step;

  johnson_code_check #(.N(N), .PW(PW)) u_check (
    .code_in (code_in),
    .legal   (legal),
    .phase   (dec)
  );

  // phase_out doubles as the reference phase for step classification
  assign nxt    = (phase_out == LAST) ? '0 : phase_out + PW'(1);
  assign gc_inc = (good_cnt == GOAL) ? good_cnt : good_cnt + GW'(1);

`ifdef JOHN_DEC_BIDIR_EN
  logic [PW-1:0] prv;
  assign prv = (phase_out == '0) ? LAST : phase_out - PW'(1);
`endif

  // Classify the decoded phase against the reference phase
  always_comb begin
    step = STEP_BAD;
    if (dec == phase_out) step = STEP_HOLD;
    else if (dec == nxt) step = STEP_FWD;
`ifdef JOHN_DEC_BIDIR_EN
    else if (dec == prv) step = STEP_BWD;
`endif
  end

  // Tracking FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      phase_out <= '0;
      phase_vld <= 1'b0;
      illegal   <= 1'b0;
      step_err  <= 1'b0;
      locked    <= 1'b0;
      rev_cnt   <= '0;
    end else begin
      phase_vld <= 1'b0;
      illegal   <= 1'b0;
      step_err  <= 1'b0;
      if (code_vld) begin
        if (!legal) begin
          illegal  <= 1'b1;
          state    <= SEARCH;
          good_cnt <= '0;
          locked   <= 1'b0;
        end else begin
          phase_out <= dec;
          phase_vld <= 1'b1;
          case (state)
            SEARCH: begin
              state    <= ACQ;
              good_cnt <= '0;
            end
            ACQ: begin
              case (step)
                STEP_HOLD: ;
                STEP_FWD, STEP_BWD: begin
                  good_cnt <= gc_inc;
                  if (gc_inc == GOAL) begin
                    state  <= LOCK;
                    locked <= 1'b1;
                  end
                end
                default: begin
                  step_err <= 1'b1;
                  state    <= SEARCH;
                  good_cnt <= '0;
                end
              endcase
            end
            LOCK: begin
              case (step)
                STEP_HOLD: ;
                STEP_FWD: begin
                  good_cnt <= gc_inc;
                  if (phase_out == LAST && dec == '0) rev_cnt <= rev_cnt + RW'(1);
                end
`ifdef JOHN_DEC_BIDIR_EN
                STEP_BWD: begin
                  good_cnt <= gc_inc;
                  if (phase_out == '0 && dec == LAST) rev_cnt <= rev_cnt - RW'(1);
                end
`endif
                default: begin
                  step_err <= 1'b1;
                  state    <= SEARCH;
                  good_cnt <= '0;
                  locked   <= 1'b0;
                end
              endcase
            end
            default: begin
              state    <= SEARCH;
              good_cnt <= '0;
              locked   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
